arbitrated_multiplexer: RTL and testbench
=========================================

// Module: arbitrated_multiplexer
// PURPOSE
//   N-input to 1-output multiplexer with per-channel valid/ready handshakes and a built-in arbiter.
//   Replaces the plain select-driven mux where several producers compete for one consumer, e.g. bus masters to a memory port.
//   Picks one requesting channel per transfer, registers its data, and reports which channel won.
//   Selectable fixed-priority or round-robin arbitration; one registered output stage.
// PARAMETERS
//   PORT_TYPE            logic[0:0]                 payload type carried per channel
//   NUMBER_OF_INPUTS     4                          channel count, >= 2
//   SELECT_SIGNAL_WIDTH  $clog2(NUMBER_OF_INPUTS)   width of the winner index
//   ROUND_ROBIN          1                          1 = round-robin, 0 = fixed priority (channel 0 highest)
// PORTS
//   clock          in   1                      single clock, rising edge
//   reset          in   1                      asynchronous, active-high
//   inputSignals   in   PORT_TYPE x N          per-channel payload
//   inputValid     in   N                      channel i has a payload
//   inputReady     out  N                      channel i payload accepted this cycle
//   outputSignal   out  PORT_TYPE              registered winning payload
//   outputSelect   out  SELECT_SIGNAL_WIDTH    index of the channel that supplied outputSignal
//   outputValid    out  1                      outputSignal/outputSelect hold a transfer
//   outputReady    in   1                      consumer accepts the transfer
// BEHAVIOUR
//   - Reset (async, any cycle): outputValid=0, outputSignal=0, outputSelect=0, round-robin pointer=0. Any in-flight transfer is dropped.
//   - inputReady is 0 in every cycle while reset is high.
//   - canAccept = !outputValid || outputReady.
//   - Grant, combinational from inputValid, pointer and canAccept:
//       - at most one inputReady bit is high;
//       - inputReady[w]=1 only if canAccept && inputValid[w].
//   - Acceptance edge: outputSignal<=inputSignals[w], outputSelect<=w, outputValid<=1. Latency is 1 cycle from acceptance.
//   - Drain edge (outputValid && outputReady, no new grant): outputValid<=0. outputSignal and outputSelect hold their values.
//   - Simultaneous drain and grant: the new payload replaces the old one with no bubble. Full throughput is 1 transfer per clock.
//   - Stall (outputValid && !outputReady): outputSignal, outputSelect and outputValid all hold. inputReady is all zeros.
//   - Fixed priority: w is the lowest index with inputValid set.
//   - Round-robin: search starts at the pointer and goes upward, wrapping N-1 -> 0.
//       - After a grant to w: pointer <= (w+1) mod N; wrap is explicit and correct for non-power-of-2 N.
//       - Pointer changes only on a grant.
//   - No valid inputs: no grant, the pointer holds, and outputValid follows the drain rule.
//   - Producers must not make inputValid depend on inputReady. A producer holds its payload until it sees inputReady.
//   - No combinational path from outputReady to outputSignal.
// STRUCTURE
//   - Package multiplexer_pkg holds:
//       - the arbitration mode enum: FIXED_PRIORITY, ROUND_ROBIN (ROUND_ROBIN parameter maps onto it);
//       - function nextIndex(index, N), the mod-N increment.
//   - Sub-module round_robin_arbiter, parameterised by N and mode:
//       - inputs: request[N], enable, clock, reset;
//       - outputs: one-hot grant[N] and the binary grantIndex;
//       - owns the pointer register.
//   - Top level keeps the output register and the handshake logic.
// TESTING  (N=4, PORT_TYPE=logic[7:0], outputReady=1 unless stated)
//   1. Reset mid-transfer:
//        - stimulus: outputValid=1, then assert reset between clock edges;
//        - response: outputValid, outputSignal and outputSelect are 0 immediately, inputReady=0000 while reset is high.
//   2. Single channel:
//        - stimulus: inputValid=0100, inputSignals[2]=8'hA5;
//        - response: inputReady=0100 that cycle; next cycle outputSignal=A5, outputSelect=2, outputValid=1.
//   3. Round-robin fairness:
//        - stimulus: all four channels valid continuously, channel i payload = 8'h10+i;
//        - response: outputSelect sequence 0,1,2,3,0,1, one transfer per clock.
//   4. Fixed priority:
//        - stimulus: ROUND_ROBIN=0, inputValid=1010 for 3 cycles;
//        - response: outputSelect=1 on every cycle; channel 3 is never granted.
//   5. Backpressure:
//        - stimulus: outputReady=0 for 3 cycles with outputValid=1 holding payload 8'h33;
//        - response: payload held and inputReady=0000 during the stall; on release, the next winner appears 1 cycle later with no loss or duplicate.
//   6. Pointer wrap and skip:
//        - stimulus: pointer=3, inputValid=0011 (channel 3 not requesting);
//        - response: grant 0, pointer=1; next cycle grant 1, pointer=2.

Source files
------------

// File: rtl/multiplexer_pkg.sv
// Shared arbitration types and helpers for the arbitrated multiplexer.
package multiplexer_pkg;

    typedef enum logic {
        FIXED_PRIORITY = 1'b0,
        ROUND_ROBIN    = 1'b1
    } arb_mode_t;

    // Explicit wrap so non-power-of-two channel counts index correctly.
    function automatic int nextIndex(input int index, input int n);
        return (index >= n - 1) ? 0 : index + 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// One-hot arbiter with fixed-priority or rotating search; the grant is combinational.
// The rotation pointer advances to the channel after the winner, and only on a grant.
module round_robin_arbiter
    import multiplexer_pkg::*;
#(
    parameter int        N    = 4,
    parameter arb_mode_t MODE = ROUND_ROBIN,
    parameter int        W    = $clog2(N)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] request,
    input  logic         enable,
    output logic [N-1:0] grant,
    output logic [W-1:0] grantIndex
);

    logic [W-1:0] pointer;
    logic [W:0]   sum;
    logic [W-1:0] idx;
    logic         found;

    always_comb begin
        grant      = '0;
        grantIndex = '0;
        found      = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            // Fixed priority is just a search that always starts at channel 0.
            sum = (MODE == ROUND_ROBIN) ? ({1'b0, pointer} + (W+1)'(k)) : (W+1)'(k);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            idx = sum[W-1:0];
            if (enable && !found && request[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grantIndex = idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer <= '0;
        end else if (MODE == ROUND_ROBIN && found) begin
            pointer <= W'(nextIndex(int'(grantIndex), N));
        end
    end

endmodule

// File: rtl/arbitrated_multiplexer.sv
// N-to-1 valid/ready mux with built-in arbiter and one registered output stage (1-cycle latency).
// A stalled output (valid && !ready) blocks every input; drain and new grant overlap for full throughput.
module arbitrated_multiplexer #(
    parameter type PORT_TYPE           = logic [0:0],
    parameter int  NUMBER_OF_INPUTS    = 4,
    parameter int  SELECT_SIGNAL_WIDTH = $clog2(NUMBER_OF_INPUTS),
    parameter bit  ROUND_ROBIN         = 1'b1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  PORT_TYPE                       inputSignals [NUMBER_OF_INPUTS],
    input  logic [NUMBER_OF_INPUTS-1:0]    inputValid,
    output logic [NUMBER_OF_INPUTS-1:0]    inputReady,
    output PORT_TYPE                       outputSignal,
    output logic [SELECT_SIGNAL_WIDTH-1:0] outputSelect,
    output logic                           outputValid,
    input  logic                           outputReady
);
    import multiplexer_pkg::*;

    localparam arb_mode_t MODE = ROUND_ROBIN ? multiplexer_pkg::ROUND_ROBIN
                                             : multiplexer_pkg::FIXED_PRIORITY;

    logic                           can_accept;
    logic                           enable;
    logic [NUMBER_OF_INPUTS-1:0]    grant;
    logic [SELECT_SIGNAL_WIDTH-1:0] grant_index;

    assign can_accept = !outputValid || outputReady;
    // Gating with reset keeps every inputReady low while reset is held.
    assign enable     = can_accept && !reset;
    assign inputReady = grant;

    round_robin_arbiter #(
        .N    (NUMBER_OF_INPUTS),
        .MODE (MODE),
        .W    (SELECT_SIGNAL_WIDTH)
    ) u_arbiter (
        .clock      (clock),
        .reset      (reset),
        .request    (inputValid),
        .enable     (enable),
        .grant      (grant),
        .grantIndex (grant_index)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outputValid  <= 1'b0;
            outputSignal <= '0;
            outputSelect <= '0;
        end else if (|grant) begin
            outputValid  <= 1'b1;
            outputSignal <= inputSignals[grant_index];
            outputSelect <= grant_index;
        end else if (outputReady) begin
            outputValid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arbitrated_multiplexer.sv
// Bench for arbitrated_multiplexer: round-robin and fixed-priority instances share one set of inputs.
module tb_arbitrated_multiplexer;

    logic       clock = 1'b0;
    logic       reset;
    logic       ordy;
    logic [3:0] vld;
    logic [7:0] sigs [4];

    logic [3:0] rdy_rr, rdy_fp;
    logic [7:0] osig_rr, osig_fp;
    logic [1:0] osel_rr, osel_fp;
    logic       ov_rr, ov_fp;

    int checks = 0;
    int errors = 0;

    arbitrated_multiplexer #(
        .PORT_TYPE(logic [7:0]), .NUMBER_OF_INPUTS(4), .SELECT_SIGNAL_WIDTH(2), .ROUND_ROBIN(1'b1)
    ) dut_rr (
        .clock(clock), .reset(reset), .inputSignals(sigs), .inputValid(vld), .inputReady(rdy_rr),
        .outputSignal(osig_rr), .outputSelect(osel_rr), .outputValid(ov_rr), .outputReady(ordy)
    );

    arbitrated_multiplexer #(
        .PORT_TYPE(logic [7:0]), .NUMBER_OF_INPUTS(4), .SELECT_SIGNAL_WIDTH(2), .ROUND_ROBIN(1'b0)
    ) dut_fp (
        .clock(clock), .reset(reset), .inputSignals(sigs), .inputValid(vld), .inputReady(rdy_fp),
        .outputSignal(osig_fp), .outputSelect(osel_fp), .outputValid(ov_fp), .outputReady(ordy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
        int         sel;
        logic       ov;
    } vec_t;

    vec_t tbl [11];

    // Reference model state: index 0 = round-robin instance, 1 = fixed priority.
    logic       m_ov  [2];
    logic [7:0] m_sig [2];
    int         m_sel [2];
    int         m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic default_payloads();
        for (int i = 0; i < 4; i++) sigs[i] = 8'h10 + 8'(i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vld   = 4'b0000;
        ordy  = 1'b1;
        tick();
        chk("reset_ov_rr", 32'(ov_rr), 0);
        chk("reset_ov_fp", 32'(ov_fp), 0);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_ov[k]  = 1'b0;
            m_sig[k] = 8'h00;
            m_sel[k] = 0;
        end
        m_ptr = 0;
    endtask

    // Whichever valid channel comes first in the arbitration order wins, if the output can take it.
    function automatic int model_winner(input int k);
        int order_start;
        int c;
        if (m_ov[k] && !ordy) return -1;
        order_start = (k == 0) ? m_ptr : 0;
        for (int j = 0; j < 4; j++) begin
            c = (order_start + j) % 4;
            if (vld[c]) return c;
        end
        return -1;
    endfunction

    initial begin
        int w [2];
        logic [3:0] exp_rdy;

        reset = 1'b1;
        vld   = 4'b0000;
        ordy  = 1'b1;
        default_payloads();
        @(negedge clock);

        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 0, 1'b1};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1, 1'b1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 2, 1'b1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 3, 1'b1};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 0, 1'b1};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1, 1'b1};
        tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1, 1'b0};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1, 1'b0};
        tbl[8]  = '{4'b1000, 1'b0, 4'b1000, 3, 1'b1};
        tbl[9]  = '{4'b0110, 1'b0, 4'b0000, 3, 1'b1};
        tbl[10] = '{4'b0110, 1'b1, 4'b0010, 1, 1'b1};

        // Single channel, then pointer wrap past a non-requesting channel 3.
        do_reset();
        sigs[2] = 8'hA5;
        vld = 4'b0100;
        #1 chk("single_rdy", 32'(rdy_rr), 32'b0100);
        tick();
        chk("single_sig", 32'(osig_rr), 32'hA5);
        chk("single_sel", 32'(osel_rr), 2);
        chk("single_ov", 32'(ov_rr), 1);
        sigs[2] = 8'h12;
        vld = 4'b0011;
        #1 chk("wrap_rdy0", 32'(rdy_rr), 32'b0001);
        tick();
        chk("wrap_sel0", 32'(osel_rr), 0);
        #1 chk("wrap_rdy1", 32'(rdy_rr), 32'b0010);
        tick();
        chk("wrap_sel1", 32'(osel_rr), 1);
        vld = 4'b1111;
        #1 chk("wrap_ptr2", 32'(rdy_rr), 32'b0100);
        vld = 4'b0000;

        // Round-robin fairness, drain, and stall-with-backpressure vectors.
        do_reset();
        for (int r = 0; r < 11; r++) begin
            vld  = tbl[r].vld;
            ordy = tbl[r].ordy;
            #1 chk($sformatf("tbl%0d_rdy", r), 32'(rdy_rr), 32'(tbl[r].rdy));
            tick();
            chk($sformatf("tbl%0d_sel", r), 32'(osel_rr), 32'(tbl[r].sel));
            chk($sformatf("tbl%0d_ov", r), 32'(ov_rr), 32'(tbl[r].ov));
            chk($sformatf("tbl%0d_sig", r), 32'(osig_rr), 32'h10 + 32'(tbl[r].sel));
        end

        // Backpressure holding payload 33 for three cycles.
        do_reset();
        sigs[0] = 8'h33;
        vld = 4'b0001;
        tick();
        vld  = 4'b1110;
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_rdy", 32'(rdy_rr), 0);
            tick();
            chk("stall_sig", 32'(osig_rr), 32'h33);
            chk("stall_sel", 32'(osel_rr), 0);
            chk("stall_ov", 32'(ov_rr), 1);
        end
        ordy = 1'b1;
        #1 chk("release_rdy", 32'(rdy_rr), 32'b0010);
        tick();
        chk("release_sig", 32'(osig_rr), 32'h11);
        chk("release_sel", 32'(osel_rr), 1);
        vld = 4'b0000;
        tick();
        chk("drain_ov", 32'(ov_rr), 0);
        chk("drain_sig_hold", 32'(osig_rr), 32'h11);
        sigs[0] = 8'h10;

        // Fixed priority never serves channel 3 while channel 1 requests.
        do_reset();
        vld = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1 chk("fp_rdy", 32'(rdy_fp), 32'b0010);
            tick();
            chk("fp_sel", 32'(osel_fp), 1);
            chk("fp_ov", 32'(ov_fp), 1);
        end

        // Asynchronous reset between clock edges while a transfer is held.
        do_reset();
        sigs[3] = 8'h5C;
        vld = 4'b1000;
        tick();
        chk("pre_reset_ov", 32'(ov_rr), 1);
        vld = 4'b1111;
        #2 reset = 1'b1;
        #1;
        chk("arst_ov", 32'(ov_rr), 0);
        chk("arst_sig", 32'(osig_rr), 0);
        chk("arst_sel", 32'(osel_rr), 0);
        chk("arst_rdy_rr", 32'(rdy_rr), 0);
        chk("arst_rdy_fp", 32'(rdy_fp), 0);
        @(posedge clock);
        #1 chk("arst_rdy_held", 32'(rdy_rr), 0);
        @(negedge clock);
        sigs[3] = 8'h13;

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            vld  = 4'($urandom_range(0, 15));
            ordy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) sigs[i] = 8'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                w[k] = model_winner(k);
                exp_rdy = (w[k] >= 0) ? (4'b0001 << w[k]) : 4'b0000;
                chk((k == 0) ? "rand_rdy_rr" : "rand_rdy_fp",
                    32'((k == 0) ? rdy_rr : rdy_fp), 32'(exp_rdy));
                if (w[k] >= 0) begin
                    m_ov[k]  = 1'b1;
                    m_sig[k] = sigs[w[k]];
                    m_sel[k] = w[k];
                    if (k == 0) m_ptr = (w[k] + 1) % 4;
                end else if (ordy) begin
                    m_ov[k] = 1'b0;
                end
            end
            tick();
            chk("rand_ov_rr", 32'(ov_rr), 32'(m_ov[0]));
            chk("rand_sig_rr", 32'(osig_rr), 32'(m_sig[0]));
            chk("rand_sel_rr", 32'(osel_rr), 32'(m_sel[0]));
            chk("rand_ov_fp", 32'(ov_fp), 32'(m_ov[1]));
            chk("rand_sig_fp", 32'(osig_fp), 32'(m_sig[1]));
            chk("rand_sel_fp", 32'(osel_fp), 32'(m_sel[1]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
